// File: rtl/lcd_power_seq_if.sv
// Panel-side signal bundle for the LCD power sequencer.
// The master modport is the controller/bench side, the slave modport is the sequencer.
interface lcd_power_seq_if #(
    parameter int PWM_W = 8
);
    logic             i_en;
    logic             i_vs_pulse;
    logic [PWM_W-1:0] i_duty;
    logic             lcd_rst_n;
    logic             o_tg_en;
    logic             lcd_bl;
    logic             o_ready;
    logic             o_err;
    logic [2:0]       o_state;

    modport master (
        output i_en, i_vs_pulse, i_duty,
        input  lcd_rst_n, o_tg_en, lcd_bl, o_ready, o_err, o_state
    );

    modport slave (
        input  i_en, i_vs_pulse, i_duty,
        output lcd_rst_n, o_tg_en, lcd_bl, o_ready, o_err, o_state
    );
endinterface

// File: rtl/lcd_power_seq.sv
// LCD panel power/bring-up sequencer: panel reset, timing generator enable,
// and a glitch-free backlight PWM that only runs while video is valid.
module lcd_power_seq #(
    parameter int RST_LOW_CYC     = 1000,
    parameter int RST_WAIT_CYC    = 6000,
    parameter int BL_DELAY_FRAMES = 2,
    parameter int VS_TIMEOUT      = 2000000,
    parameter int PWM_W           = 8
) (
    input  logic           clk,
    input  logic           i_rst_n,
    lcd_power_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RST   = 3'd1,
        S_WAIT  = 3'd2,
        S_TG_ON = 3'd3,
        S_ON    = 3'd4,
        S_PD    = 3'd5
    } state_t;

    localparam int MAX_AB  = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > VS_TIMEOUT) ? MAX_AB : VS_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int FW      = (BL_DELAY_FRAMES > 1) ? $clog2(BL_DELAY_FRAMES) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT_CYC - 1);
    localparam logic [CW-1:0] VS_LAST   = CW'(VS_TIMEOUT - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BL_DELAY_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [FW-1:0]    frm_q, frm_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             set_err, clr_err;

    logic rst_n_q, rst_n_d;
    logic tg_en_q, tg_en_d;
    logic bl_act_q, bl_act_d;
    logic bl_q, bl_d;
    logic ready_q, ready_d;
    logic err_q, err_d;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_OFF;
            cyc_q   <= '0;
            frm_q   <= '0;
            pwm_q   <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            frm_q   <= frm_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
        end
    end

    // A falling i_en is checked first in every state so it beats frame completion and timeout.
    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        set_err = 1'b0;
        clr_err = 1'b0;
        case (state_q)
            S_OFF: begin
                if (bus.i_en) begin
                    state_d = S_RST;
                    clr_err = 1'b1;
                end
            end
            S_RST: begin
                if (!bus.i_en)             state_d = S_OFF;
                else if (cyc_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.i_en)              state_d = S_OFF;
                else if (cyc_q == WAIT_LAST) state_d = S_TG_ON;
            end
            S_TG_ON: begin
                if (!bus.i_en) begin
                    state_d = S_PD;
                end else if (bus.i_vs_pulse) begin
                    if (frm_q == FRM_LAST) state_d = S_ON;
                    else                   frm_d   = frm_q + 1'b1;
                end else if (cyc_q == VS_LAST) begin
                    state_d = S_PD;
                    set_err = 1'b1;
                end
            end
            S_ON: begin
                if (!bus.i_en) state_d = S_PD;
            end
            S_PD: begin
                if (bus.i_vs_pulse || cyc_q == VS_LAST) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
        if (state_d != S_TG_ON) frm_d = '0;
    end

    // The cycle counter restarts on any state change and on strobes while waiting for frames.
    always_comb begin
        cyc_d = cyc_q;
        if (state_d != state_q ||
            (bus.i_vs_pulse && (state_q == S_TG_ON || state_q == S_PD)))
            cyc_d = '0;
        else if (cyc_q != '1)
            cyc_d = cyc_q + 1'b1;
    end

    // Outputs are decoded from the next state so the registered values line up with o_state.
    always_comb begin
        pwm_d    = pwm_q + 1'b1;
        duty_d   = (pwm_q == '1) ? bus.i_duty : duty_q;
        rst_n_d  = (state_d == S_WAIT) || (state_d == S_TG_ON) ||
                   (state_d == S_ON)   || (state_d == S_PD);
        tg_en_d  = (state_d == S_TG_ON) || (state_d == S_ON) || (state_d == S_PD);
        ready_d  = (state_d == S_ON);
        bl_act_d = (state_d == S_ON) && (bl_act_q || pwm_d == '0);
        bl_d     = bl_act_d && (pwm_d < duty_d);
        err_d    = err_q;
        if (clr_err)      err_d = 1'b0;
        else if (set_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_n_q  <= 1'b0;
            tg_en_q  <= 1'b0;
            bl_act_q <= 1'b0;
            bl_q     <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rst_n_q  <= rst_n_d;
            tg_en_q  <= tg_en_d;
            bl_act_q <= bl_act_d;
            bl_q     <= bl_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bus.lcd_rst_n = rst_n_q;
    assign bus.o_tg_en   = tg_en_q;
    assign bus.lcd_bl    = bl_q;
    assign bus.o_ready   = ready_q;
    assign bus.o_err     = err_q;
    assign bus.o_state   = state_q;

endmodule
